// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC packet type, widths and output-port indices
package noc_pkg;
    localparam int DATA_W = 32;
    localparam int X_W    = 2;
    localparam int Y_W    = 2;
    localparam int M      = 5;
    typedef struct packed {
        logic [X_W-1:0]    dest_x;
        logic [Y_W-1:0]    dest_y;
        logic [DATA_W-1:0] data;
    } packet_t;
    typedef enum logic [2:0] {
        NORTH = 3'd0,
        EAST  = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        LOCAL = 3'd4
    } port_t;
endpackage

// File: rtl/input_port_unit_xy_route.sv
// xy_route: dimension-ordered XY routing to a one-hot output-port request
module xy_route
    import noc_pkg::*;
#(
    parameter int X_LOC = 0,
    parameter int Y_LOC = 0
) (
    input  logic [X_W-1:0] dest_x,
    input  logic [Y_W-1:0] dest_y,
    output logic [M-1:0]   req
);
    localparam logic [X_W-1:0] XL = X_W'(X_LOC);
    localparam logic [Y_W-1:0] YL = Y_W'(Y_LOC);
    port_t p;
    // resolve X first, then Y, falling through to the local core
    always_comb begin
        p = dest_x > XL ? EAST : dest_x < XL ? WEST : dest_y > YL ? SOUTH : dest_y < YL ? NORTH : LOCAL;
        req = M'(1) << p;
    end
endmodule

// File: rtl/input_port_unit.sv
// input_port_unit: router input FIFO with credit-style enable and XY route request
module input_port_unit
    import noc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int X_LOC = 0,
    parameter int Y_LOC = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ce,
    input  packet_t      i_data,
    input  logic         i_data_val,
    output logic         o_en,
    output packet_t      o_data,
    output logic         o_data_val,
    output logic [M-1:0] o_output_req,
    input  logic         i_input_grant,
    output logic         o_overflow
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    packet_t       mem [DEPTH];
    logic          full, empty, push, pop;
    logic [M-1:0]  req;

    assign full         = count == (AW+1)'(DEPTH);
    assign empty        = count == '0;
    assign push         = ce && i_data_val && !full;
    assign pop          = ce && i_input_grant && !empty;
    assign o_en         = !full;
    assign o_data       = mem[rd_ptr];
    assign o_data_val   = !empty;
    assign o_output_req = o_data_val ? req : '0;

    xy_route #(.X_LOC(X_LOC), .Y_LOC(Y_LOC)) u_route (
        .dest_x (o_data.dest_x),
        .dest_y (o_data.dest_y),
        .req    (req)
    );

    // pointers, occupancy and sticky overflow; full is judged before any same-cycle pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (ce && i_data_val && full) o_overflow <= 1'b1;
        end
    end

    // packet storage is left unreset; only occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= i_data;
    end
endmodule
